// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-RAM port arbiter: FSM encoding and the
// load opcode constants also used by load_buffer.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2
    } arb_state_e;

    localparam logic [6:0] OP_LB  = 7'd11;
    localparam logic [6:0] OP_LH  = 7'd12;
    localparam logic [6:0] OP_LW  = 7'd13;
    localparam logic [6:0] OP_LBU = 7'd14;
    localparam logic [6:0] OP_LHU = 7'd15;

    localparam int STARVE_CNT_W = 4;
    localparam int LAT_CNT_W    = 3;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of cycles a pending store was refused; force_o lets the
// store beat a competing load once the limit is reached.
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic st_req_i,
    input  logic st_gnt_i,
    output logic force_o
);

    logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (st_gnt_i) begin
            cnt_d = '0;
        end else if (st_req_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_o = (cnt_q >= STARVE_CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port data RAM arbiter: loads first, stores forced through on
// starvation or a full store buffer; squashes mispredicted speculative loads.
// Optional perf counters are built when MEM_PORT_ARB_PERF_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 15,
    parameter int DATA_WIDTH   = 32,
    parameter int RES_ID_WIDTH = 32,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      ld_req_i,
    input  logic [ADDR_WIDTH-1:0]     ld_addr_i,
    input  logic [RES_ID_WIDTH-1:0]   ld_res_id_i,
    input  logic                      ld_speculative_i,
    output logic                      ld_gnt_o,
    input  logic                      st_req_i,
    input  logic                      st_full_i,
    input  logic [ADDR_WIDTH-1:0]     st_addr_i,
    input  logic [DATA_WIDTH-1:0]     st_data_i,
    input  logic [DATA_WIDTH/8-1:0]   st_be_i,
    output logic                      st_gnt_o,
    input  logic                      prediction_success_i,
    input  logic                      prediction_failed_i,
    output logic                      ram_en_o,
    output logic                      ram_we_o,
    output logic [ADDR_WIDTH-1:0]     ram_addr_o,
    output logic [DATA_WIDTH-1:0]     ram_wdata_o,
    output logic [DATA_WIDTH/8-1:0]   ram_be_o,
    input  logic [DATA_WIDTH-1:0]     ram_rdata_i,
    output logic                      ld_rdata_valid_o,
    output logic [DATA_WIDTH-1:0]     ld_rdata_o,
    output logic [RES_ID_WIDTH-1:0]   ld_rdata_res_id_o,
    output logic                      busy_o
`ifdef MEM_PORT_ARB_PERF_EN
    ,
    output logic [31:0]               perf_ld_cnt_o,
    output logic [31:0]               perf_st_cnt_o,
    output logic [31:0]               perf_kill_cnt_o,
    output logic [31:0]               perf_starve_cnt_o
`endif
);

    arb_state_e                state_q;
    logic [LAT_CNT_W-1:0]      lat_cnt_q;
    logic [RES_ID_WIDTH-1:0]   res_id_q;
    logic                      spec_q;
    logic                      killed_q;
    logic                      ram_en_q, ram_we_q;
    logic [ADDR_WIDTH-1:0]     ram_addr_q;
    logic [DATA_WIDTH-1:0]     ram_wdata_q;
    logic [DATA_WIDTH/8-1:0]   ram_be_q;
    logic                      ld_rdata_valid_q;
    logic [DATA_WIDTH-1:0]     ld_rdata_q;
    logic [RES_ID_WIDTH-1:0]   ld_rdata_res_id_q;

    logic starve_force, st_win, ld_win, idle, ld_done, kill_now;

    mem_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .st_req_i (st_req_i),
        .st_gnt_i (st_gnt_o),
        .force_o  (starve_force)
    );

    // Grants are gated by reset so every output reads 0 while reset is held.
    assign idle     = (state_q == IDLE) && !reset_i;
    assign st_win   = st_req_i && (st_full_i || starve_force || !ld_req_i);
    assign ld_win   = ld_req_i && !st_win;
    assign st_gnt_o = idle && st_win;
    assign ld_gnt_o = idle && ld_win;
    assign busy_o   = (state_q != IDLE);
    assign ld_done  = (state_q == RD_WAIT) && (lat_cnt_q == '0);
    assign kill_now = killed_q || (prediction_failed_i && spec_q);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q           <= IDLE;
            lat_cnt_q         <= '0;
            res_id_q          <= '0;
            spec_q            <= 1'b0;
            killed_q          <= 1'b0;
            ram_en_q          <= 1'b0;
            ram_we_q          <= 1'b0;
            ram_addr_q        <= '0;
            ram_wdata_q       <= '0;
            ram_be_q          <= '0;
            ld_rdata_valid_q  <= 1'b0;
            ld_rdata_q        <= '0;
            ld_rdata_res_id_q <= '0;
        end else begin
            ram_en_q         <= 1'b0;
            ld_rdata_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    killed_q <= 1'b0;
                    if (prediction_success_i || prediction_failed_i) begin
                        spec_q <= 1'b0;
                    end
                    if (st_win) begin
                        state_q     <= WR;
                        ram_en_q    <= 1'b1;
                        ram_we_q    <= 1'b1;
                        ram_addr_q  <= st_addr_i;
                        ram_wdata_q <= st_data_i;
                        ram_be_q    <= st_be_i;
                    end else if (ld_win) begin
                        state_q    <= RD_WAIT;
                        ram_en_q   <= 1'b1;
                        ram_we_q   <= 1'b0;
                        ram_addr_q <= ld_addr_i;
                        res_id_q   <= ld_res_id_i;
                        lat_cnt_q  <= LAT_CNT_W'(RD_LATENCY);
                        // A branch resolving in the grant cycle covers this load.
                        spec_q     <= ld_speculative_i && !prediction_success_i
                                      && !prediction_failed_i;
                        killed_q   <= ld_speculative_i && prediction_failed_i;
                    end
                end
                RD_WAIT: begin
                    if (prediction_failed_i && spec_q) begin
                        killed_q <= 1'b1;
                    end
                    if (prediction_success_i || prediction_failed_i) begin
                        spec_q <= 1'b0;
                    end
                    if (ld_done) begin
                        state_q           <= IDLE;
                        spec_q            <= 1'b0;
                        ld_rdata_q        <= ram_rdata_i;
                        ld_rdata_res_id_q <= res_id_q;
                        ld_rdata_valid_q  <= !kill_now;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end
                end
                WR:      state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_en_o          = ram_en_q;
    assign ram_we_o          = ram_we_q;
    assign ram_addr_o        = ram_addr_q;
    assign ram_wdata_o       = ram_wdata_q;
    assign ram_be_o          = ram_be_q;
    assign ld_rdata_valid_o  = ld_rdata_valid_q;
    assign ld_rdata_o        = ld_rdata_q;
    assign ld_rdata_res_id_o = ld_rdata_res_id_q;

`ifdef MEM_PORT_ARB_PERF_EN
    logic [31:0] perf_ld_q, perf_st_q, perf_kill_q, perf_starve_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            perf_ld_q     <= '0;
            perf_st_q     <= '0;
            perf_kill_q   <= '0;
            perf_starve_q <= '0;
        end else begin
            if (ld_gnt_o)                     perf_ld_q     <= perf_ld_q + 1'b1;
            if (st_gnt_o)                     perf_st_q     <= perf_st_q + 1'b1;
            if (ld_done && kill_now)          perf_kill_q   <= perf_kill_q + 1'b1;
            if (st_gnt_o && starve_force)     perf_starve_q <= perf_starve_q + 1'b1;
        end
    end

    assign perf_ld_cnt_o     = perf_ld_q;
    assign perf_st_cnt_o     = perf_st_q;
    assign perf_kill_cnt_o   = perf_kill_q;
    assign perf_starve_cnt_o = perf_starve_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; RAM traffic and load results are
// checked by a negedge monitor against queues filled by the stimulus.
module tb_mem_port_arbiter;

    localparam int AW = 15;
    localparam int DW = 32;
    localparam int RW = 32;
    localparam int RL = 1;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    be;
    } ram_exp_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [RW-1:0] tag;
    } ld_exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          ld_req, ld_speculative, st_req, st_full;
    logic [AW-1:0] ld_addr, st_addr;
    logic [RW-1:0] ld_res_id;
    logic [DW-1:0] st_data;
    logic [3:0]    st_be;
    logic          prediction_success, prediction_failed;
    logic          ld_gnt, st_gnt, ram_en, ram_we, ld_rdata_valid, busy;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata, ld_rdata;
    logic [3:0]    ram_be;
    logic [RW-1:0] ld_rdata_res_id;
`ifdef MEM_PORT_ARB_PERF_EN
    logic [31:0]   perf_ld, perf_st, perf_kill, perf_starve;
`endif

    int checks = 0;
    int errors = 0;
    ram_exp_t exp_ram[$];
    ld_exp_t  exp_ld[$];
    logic [DW-1:0] mem [0:255];

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RES_ID_WIDTH(RW),
        .RD_LATENCY(RL), .STARVE_LIMIT(4)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_res_id_i(ld_res_id),
        .ld_speculative_i(ld_speculative), .ld_gnt_o(ld_gnt),
        .st_req_i(st_req), .st_full_i(st_full), .st_addr_i(st_addr),
        .st_data_i(st_data), .st_be_i(st_be), .st_gnt_o(st_gnt),
        .prediction_success_i(prediction_success), .prediction_failed_i(prediction_failed),
        .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_be_o(ram_be), .ram_rdata_i(ram_rdata),
        .ld_rdata_valid_o(ld_rdata_valid), .ld_rdata_o(ld_rdata),
        .ld_rdata_res_id_o(ld_rdata_res_id), .busy_o(busy)
`ifdef MEM_PORT_ARB_PERF_EN
        , .perf_ld_cnt_o(perf_ld), .perf_st_cnt_o(perf_st)
        , .perf_kill_cnt_o(perf_kill), .perf_starve_cnt_o(perf_starve)
`endif
    );

    // Synchronous RAM, one cycle read latency; a few words preset while in reset.
    always @(posedge clk) begin
        if (reset) begin
            mem[8'h40] <= 32'hDEADBEEF;
            mem[8'h10] <= 32'h11223344;
            mem[8'h20] <= 32'h5A5A0020;
        end else if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= mem[ram_addr[7:0]];
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && ram_en) begin
            checks++;
            if (exp_ram.size() == 0) begin
                errors++;
                $display("FAIL ram_unexpected: we=%0b addr=0x%0h with nothing expected", ram_we, ram_addr);
            end else begin
                ram_exp_t e;
                e = exp_ram.pop_front();
                if (ram_we !== e.we || ram_addr !== e.addr ||
                    (e.we && (ram_wdata !== e.wdata || ram_be !== e.be))) begin
                    errors++;
                    $display("FAIL ram_access: got we=%0b addr=0x%0h wdata=0x%0h be=%b, expected we=%0b addr=0x%0h wdata=0x%0h be=%b",
                             ram_we, ram_addr, ram_wdata, ram_be, e.we, e.addr, e.wdata, e.be);
                end
            end
        end
        if (!reset && ld_rdata_valid) begin
            checks++;
            if (exp_ld.size() == 0) begin
                errors++;
                $display("FAIL ld_unexpected: data=0x%0h tag=%0d with nothing expected", ld_rdata, ld_rdata_res_id);
            end else begin
                ld_exp_t l;
                l = exp_ld.pop_front();
                if (ld_rdata !== l.data || ld_rdata_res_id !== l.tag) begin
                    errors++;
                    $display("FAIL ld_result: got data=0x%0h tag=%0d, expected data=0x%0h tag=%0d",
                             ld_rdata, ld_rdata_res_id, l.data, l.tag);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_ram_en"}, ram_en, 0);
        chk({nm, "_ram_we"}, ram_we, 0);
        chk({nm, "_ram_addr"}, ram_addr, 0);
        chk({nm, "_ram_wdata"}, ram_wdata, 0);
        chk({nm, "_ram_be"}, ram_be, 0);
        chk({nm, "_ld_valid"}, ld_rdata_valid, 0);
        chk({nm, "_ld_rdata"}, ld_rdata, 0);
        chk({nm, "_ld_tag"}, ld_rdata_res_id, 0);
        chk({nm, "_ld_gnt"}, ld_gnt, 0);
        chk({nm, "_st_gnt"}, st_gnt, 0);
        chk({nm, "_busy"}, busy, 0);
    endtask

    // Cycle 0 is the grant cycle; pf/ps give the cycle a resolution pulse lands (-1 none).
    task automatic run_load(input string nm, input logic [AW-1:0] addr, input logic [RW-1:0] tag,
                            input logic spec, input int pf_cyc, input int ps_cyc,
                            input logic [DW-1:0] exp_data, input logic exp_valid);
        int lat;
        lat = -1;
        ld_req = 1'b1; ld_addr = addr; ld_res_id = tag; ld_speculative = spec;
        prediction_failed  = (pf_cyc == 0);
        prediction_success = (ps_cyc == 0);
        @(negedge clk);
        chk({nm, "_ld_gnt"}, ld_gnt, 1);
        chk({nm, "_st_gnt"}, st_gnt, 0);
        exp_ram.push_back('{we: 1'b0, addr: addr, wdata: '0, be: '0});
        if (exp_valid) exp_ld.push_back('{data: exp_data, tag: tag});
        for (int c = 1; c <= 6; c++) begin
            tick();
            ld_req = 1'b0; ld_speculative = 1'b0;
            prediction_failed  = (pf_cyc == c);
            prediction_success = (ps_cyc == c);
            @(negedge clk);
            if (ld_rdata_valid && lat < 0) lat = c;
            if (c == 1) chk({nm, "_busy_c1"}, busy, 1);
            if (c == RL + 2) chk({nm, "_idle_again"}, busy, 0);
        end
        prediction_failed = 1'b0; prediction_success = 1'b0;
        chk({nm, "_latency"}, lat, exp_valid ? RL + 2 : -1);
        tick();
    endtask

    task automatic run_store(input string nm, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [3:0] be, input logic full, input logic with_ld);
        st_req = 1'b1; st_full = full; st_addr = addr; st_data = data; st_be = be;
        ld_req = with_ld; ld_addr = 15'h0040; ld_res_id = 32'd99;
        @(negedge clk);
        chk({nm, "_st_gnt"}, st_gnt, 1);
        chk({nm, "_ld_gnt"}, ld_gnt, 0);
        exp_ram.push_back('{we: 1'b1, addr: addr, wdata: data, be: be});
        tick();
        st_req = 1'b0; st_full = 1'b0;
        @(negedge clk);
        chk({nm, "_busy_wr"}, busy, 1);
        chk({nm, "_no_gnt_in_wr"}, ld_gnt, 0);
        tick();
        ld_req = 1'b0;
        @(negedge clk);
        chk({nm, "_idle_again"}, busy, 0);
        tick();
    endtask

    // Both requesters held: loads granted at 0 and 3, starved store forced at 6.
    task automatic starve_run(input string nm);
        ld_req = 1'b1; ld_addr = 15'h0020; ld_res_id = 32'd9; ld_speculative = 1'b0;
        st_req = 1'b1; st_full = 1'b0; st_addr = 15'h0034; st_data = 32'hCAFEF00D; st_be = 4'hF;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (ld_gnt) begin
                exp_ram.push_back('{we: 1'b0, addr: 15'h0020, wdata: '0, be: '0});
                exp_ld.push_back('{data: 32'h5A5A0020, tag: 32'd9});
            end
            if (st_gnt) exp_ram.push_back('{we: 1'b1, addr: 15'h0034, wdata: 32'hCAFEF00D, be: 4'hF});
            chk($sformatf("%s_ld_gnt_c%0d", nm, c), ld_gnt, (c == 0 || c == 3) ? 1 : 0);
            chk($sformatf("%s_st_gnt_c%0d", nm, c), st_gnt, (c == 6) ? 1 : 0);
            tick();
        end
        ld_req = 1'b0; st_req = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        ld_req = 1'b0; ld_addr = '0; ld_res_id = '0; ld_speculative = 1'b0;
        st_req = 1'b0; st_full = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
        prediction_success = 1'b0; prediction_failed = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_zero("reset");
        tick();
        reset = 1'b0;
        tick();

        run_load("ld_basic", 15'h0040, 32'd7, 1'b0, -1, -1, 32'hDEADBEEF, 1'b1);
        run_store("st_full", 15'h0010, 32'hAABBCCDD, 4'b0011, 1'b1, 1'b1);
        run_load("ld_merged", 15'h0010, 32'd12, 1'b0, -1, -1, 32'h1122CCDD, 1'b1);
        run_store("st_alone", 15'h0030, 32'h01020304, 4'b1111, 1'b0, 1'b0);
        run_load("ld_st_alone", 15'h0030, 32'd13, 1'b0, -1, -1, 32'h01020304, 1'b1);

        starve_run("starve1");
        starve_run("starve2");
        run_load("ld_after_starve", 15'h0034, 32'd14, 1'b0, -1, -1, 32'hCAFEF00D, 1'b1);

        run_load("spec_kill", 15'h0040, 32'd21, 1'b1, 1, -1, 32'hDEADBEEF, 1'b0);
        run_load("spec_kill_gnt", 15'h0040, 32'd22, 1'b1, 0, -1, 32'hDEADBEEF, 1'b0);
        run_load("spec_ok_then_fail", 15'h0040, 32'd23, 1'b1, 2, 1, 32'hDEADBEEF, 1'b1);
        run_load("nonspec_fail", 15'h0020, 32'd24, 1'b0, 1, -1, 32'h5A5A0020, 1'b1);

        ld_req = 1'b1; ld_addr = 15'h0040; ld_res_id = 32'd5;
        @(negedge clk);
        chk("rst_mid_ld_gnt", ld_gnt, 1);
        tick();
        ld_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_zero("rst_mid");
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("rst_mid_no_valid_c%0d", c), ld_rdata_valid, 0);
            tick();
        end
        run_load("ld_after_rst", 15'h0040, 32'd31, 1'b0, -1, -1, 32'hDEADBEEF, 1'b1);

        repeat (4) tick();
        chk("exp_ram_drained", exp_ram.size(), 0);
        chk("exp_ld_drained", exp_ld.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
